// File: rtl/vram32_rd_arbiter_pkg.sv
// Shared definitions for the VRAM32 read arbiter: requester IDs, arbiter states
// and the legal RAM read latency range.
package vram32_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ID_BGW = 2'd0,
    ID_SPR = 2'd1,
    ID_CPU = 2'd2
  } req_id_t;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_VIDEO = 1'b1
  } arb_state_t;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// RD_LAT-deep shift register of {vld, id} that routes returning VRAM32 data
// to its owner via a one-hot valid decode of the last stage.
module vram_rd_tag_pipe
  import vram32_rd_arbiter_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       in_vld,
  input  logic [1:0] in_id,
  output logic       bgw_valid,
  output logic       spr_valid,
  output logic       cpu_valid
);

  logic [RD_LAT-1:0] vld_q;
  logic [1:0]        id_q [RD_LAT];

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) id_q[i] <= '0;
    end else begin
      vld_q[0] <= in_vld;
      id_q[0]  <= in_id;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  assign bgw_valid = vld_q[RD_LAT-1] && (id_q[RD_LAT-1] == ID_BGW);
  assign spr_valid = vld_q[RD_LAT-1] && (id_q[RD_LAT-1] == ID_SPR);
  assign cpu_valid = vld_q[RD_LAT-1] && (id_q[RD_LAT-1] == ID_CPU);

endmodule

// File: rtl/vram32_rd_arbiter.sv
// Shares one VRAM32 read port between BGW, SPR and CPU readback, one grant per cycle.
// Build option VRAM_ARB_RR_EN: round-robin between BGW and SPR during video.
module vram32_rd_arbiter
  import vram32_rd_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              blank,
  input  logic              bgw_req,
  input  logic [ADDR_W-1:0] bgw_addr,
  output logic              bgw_gnt,
  output logic              bgw_valid,
  output logic [DATA_W-1:0] bgw_q,
  input  logic              spr_req,
  input  logic [ADDR_W-1:0] spr_addr,
  output logic              spr_gnt,
  output logic              spr_valid,
  output logic [DATA_W-1:0] spr_q,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_q,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic              cpu_starved
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("vram32_rd_arbiter: RD_LAT out of range");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $error("vram32_rd_arbiter: STARVE_MAX out of range");
  end

  arb_state_t        state_q, state_d;
  logic [7:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic              grant_vld;
  logic [1:0]        grant_id;

`ifdef VRAM_ARB_RR_EN
  logic last_spr_q;
`endif

  assign cpu_starved = (starve_q == 8'(STARVE_MAX));

  always_comb begin
    bgw_gnt = 1'b0;
    spr_gnt = 1'b0;
    cpu_gnt = 1'b0;
    if (!reset) begin
      if (state_q == S_BLANK) begin
        if (cpu_req)      cpu_gnt = 1'b1;
        else if (spr_req) spr_gnt = 1'b1;
        else if (bgw_req) bgw_gnt = 1'b1;
      end else if (cpu_req && cpu_starved) begin
        cpu_gnt = 1'b1;
      end else if (bgw_req && spr_req) begin
`ifdef VRAM_ARB_RR_EN
        if (last_spr_q) bgw_gnt = 1'b1;
        else            spr_gnt = 1'b1;
`else
        bgw_gnt = 1'b1;
`endif
      end else if (bgw_req) begin
        bgw_gnt = 1'b1;
      end else if (spr_req) begin
        spr_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    grant_vld = bgw_gnt | spr_gnt | cpu_gnt;
    grant_id  = ID_BGW;
    ram_addr  = last_addr_q;
    if (cpu_gnt) begin
      grant_id = ID_CPU;
      ram_addr = cpu_addr;
    end else if (spr_gnt) begin
      grant_id = ID_SPR;
      ram_addr = spr_addr;
    end else if (bgw_gnt) begin
      ram_addr = bgw_addr;
    end
  end

  // Counter only runs while video holds the CPU off; blanking always clears it.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      S_BLANK: begin
        starve_d = '0;
        if (!blank) state_d = S_VIDEO;
      end
      S_VIDEO: begin
        if (blank) begin
          state_d  = S_BLANK;
          starve_d = '0;
        end else if (cpu_req && !cpu_gnt) begin
          if (!cpu_starved) starve_d = starve_q + 8'd1;
        end else begin
          starve_d = '0;
        end
      end
      default: begin
        state_d  = S_BLANK;
        starve_d = '0;
      end
    endcase
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_BLANK;
      starve_q    <= '0;
      last_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (grant_vld) last_addr_q <= ram_addr;
    end
  end

`ifdef VRAM_ARB_RR_EN
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      last_spr_q <= 1'b1;
    end else if (state_q == S_VIDEO && (bgw_gnt || spr_gnt)) begin
      last_spr_q <= spr_gnt;
    end
  end
`endif

  vram_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .vga_clk   (vga_clk),
    .reset     (reset),
    .in_vld    (grant_vld),
    .in_id     (grant_id),
    .bgw_valid (bgw_valid),
    .spr_valid (spr_valid),
    .cpu_valid (cpu_valid)
  );

  assign bgw_q = ram_q;
  assign spr_q = ram_q;
  assign cpu_q = ram_q;

endmodule
